// File: rtl/univ_gate_pkg.sv
// Shared constants for the universal-gate cell library.
package univ_gate_pkg;

    localparam int unsigned MAX_WIDTH   = 64;
    localparam logic        OUT_Q_RESET = 1'b0;

endpackage

// File: rtl/nor_cell.sv
// One CMOS NOR slice built from switch-level primitives: series pull-up, parallel pull-down.
module nor_cell (
    input  logic a,
    input  logic b,
    output wire  y
);

    supply1 vdd;
    supply0 vss;
    wire    mid;

    pmos p_a (mid, vdd, a);
    pmos p_b (y, mid, b);

    nmos n_a (y, vss, a);
    nmos n_b (y, vss, b);

endmodule

// File: rtl/univ_nor.sv
// WIDTH independent switch-level NOR slices with a registered copy of the result.
module univ_nor
    import univ_gate_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output wire  [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("univ_nor: WIDTH out of range");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        nor_cell u_cell (
            .a (a[i]),
            .b (b[i]),
            .y (out[i])
        );
    end

    logic [WIDTH-1:0] out_q_d;

    // Reset value is a fixed constant, not the NOR of zero inputs.
    always_comb begin
        out_q_d = out;
        if (!rst_n) begin
            out_q_d = {WIDTH{OUT_Q_RESET}};
        end
    end

    always_ff @(posedge clk) begin
        out_q <= out_q_d;
    end

endmodule

// File: tb/tb_univ_nor.sv
// Self-checking bench for univ_nor: unclocked WIDTH=1 slice and clocked WIDTH=8 instance.
module tb_univ_nor;

    logic       clk;
    logic       rst_n;
    logic [7:0] a8;
    logic [7:0] b8;
    wire  [7:0] out8;
    logic [7:0] out8_q;

    logic       a1;
    logic       b1;
    wire        out1;
    logic       out1_q;

    int n_total;
    int n_bad;

    logic [7:0] exp_q[$];
    logic [7:0] last_q;

    univ_nor #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a8),
        .b     (b8),
        .out   (out8),
        .out_q (out8_q)
    );

    // Clock and reset tied off: only the combinational path is exercised here.
    univ_nor #(.WIDTH(1)) u_dut1 (
        .clk   (1'b0),
        .rst_n (1'b1),
        .a     (a1),
        .b     (b1),
        .out   (out1),
        .out_q (out1_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle at the falling edge: compare the previous cycle's register result,
    // apply new inputs, check the combinational output, and queue the registered prediction.
    task automatic step(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic rv, input logic [7:0] exp_out);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            last_q = exp_q.pop_front();
            check_val({tag, "_q"}, out8_q, last_q);
        end
        a8    = av;
        b8    = bv;
        rst_n = rv;
        #1;
        check_val({tag, "_out"}, out8, exp_out);
        if (exp_q.size() > 0 || n_total > 0) begin
            check_val({tag, "_hold"}, out8_q, last_q);
        end
        exp_q.push_back(rv ? exp_out : 8'h00);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        last_q  = 8'h00;
        a8      = 8'h00;
        b8      = 8'h00;
        rst_n   = 1'b0;
        a1      = 1'b0;
        b1      = 1'b0;

        // WIDTH=1: a toggles every 10 ns, b every 20 ns; out high only in the first quarter.
        for (int k = 0; k < 20; k++) begin
            a1 = k[0];
            b1 = k[1];
            #5;
            check_val("w1_tt", {7'd0, out1}, {7'd0, (k % 4) == 0});
            #5;
        end

        // Clocked WIDTH=8 phase; first step has no prior register prediction to compare.
        @(negedge clk);
        a8    = 8'h00;
        b8    = 8'h00;
        rst_n = 1'b0;
        #1;
        check_val("rst0_out", out8, 8'hFF);
        exp_q.push_back(8'h00);

        step("rst1",    8'h00, 8'h00, 1'b0, 8'hFF);
        step("release", 8'h00, 8'h00, 1'b1, 8'hFF);
        step("hold_ff", 8'h00, 8'h00, 1'b1, 8'hFF);
        step("lat_a1",  8'h01, 8'h00, 1'b1, 8'hFE);
        step("lat_nxt", 8'h01, 8'h00, 1'b1, 8'hFE);
        step("idle",    8'h00, 8'h00, 1'b1, 8'hFF);
        step("mid_rst", 8'h00, 8'h00, 1'b0, 8'hFF);
        step("recover", 8'h00, 8'h00, 1'b1, 8'hFF);
        step("mix",     8'hF0, 8'h0C, 1'b1, 8'h03);
        step("zeros",   8'h00, 8'h00, 1'b1, 8'hFF);
        step("b_only",  8'h00, 8'hA5, 1'b1, 8'h5A);
        step("ones",    8'hFF, 8'hFF, 1'b1, 8'h00);
        step("x_b1",    8'hxx, 8'hFF, 1'b1, 8'h00);

        for (int i = 0; i < 24; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rr;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rr = ($urandom_range(0, 5) != 0);
            step("rand", ra, rb, rr, ~(ra | rb));
        end

        step("drain", 8'h00, 8'h00, 1'b1, 8'hFF);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            last_q = exp_q.pop_front();
            check_val("final_q", out8_q, last_q);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/univ_nor.md
# univ_nor

Universal NOR gate built at switch level from CMOS transistor primitives, with a combinational output and a registered copy of the same result. It is a leaf cell in the universal-gate library. Other gates and small logic can be composed from it, and its registered port can feed synchronous logic directly. The combinational path must work with the clock and reset left unconnected.

## Interface
Parameters:
- WIDTH, default 1: number of independent NOR bit-slices; range 1..64.

Ports:
- clk, input, 1: single clock; used only by the registered output.
- rst_n, input, 1: reset, synchronous and active-low; affects only out_q.
- a, input, WIDTH: first operand.
- b, input, WIDTH: second operand.
- out, output, WIDTH: combinational result, out[i] = ~(a[i] | b[i]).
- out_q, output, WIDTH: out sampled on the rising edge of clk.

## Operation
- Each bit i is one CMOS NOR slice:
  - pull-up: two pmos in series from supply1 to out[i], gated by a[i] and b[i];
  - pull-down: two nmos in parallel from out[i] to supply0, gated by a[i] and b[i].
- No behavioural operators on the out path; only pmos/nmos/supply primitives are allowed.
- Truth table per bit (a, b -> out):
  - 0,0 -> 1
  - 0,1 -> 0
  - 1,0 -> 0
  - 1,1 -> 0
- X/Z on either input of a slice propagates per switch-level semantics (out[i] may be X). The block does no masking or resolution.
- Slices are fully independent; there is no cross-bit interaction.
- out_q register:
  - rising clk with rst_n = 0: out_q <= 0 (all bits);
  - rising clk with rst_n = 1: out_q <= out.
- There is no enable, no handshake and no state machine.

## Timing
- out: zero-delay combinational from a/b.
  - No primitive delays are specified in RTL.
  - Must settle in the same simulation timestep as the input change.
- out_q: 1-cycle latency. The value presented at a rising edge appears after that edge and is held until the next edge.
- Reset value of out_q is all-zeros. This is deliberately not the NOR of zero inputs.
- out_q is undefined (X) until the first rising clk edge.
- rst_n is sampled only at rising clk.
  - Asserting or deasserting it between edges has no effect until the next edge.
  - Reset mid-operation clears out_q at the next edge; out keeps tracking a/b throughout.
- Inputs changing in the same timestep as the clock edge: out_q captures the pre-edge settled value (standard nonblocking sampling).
- clk/rst_n left unconnected: out fully functional; out_q stays X.

## Structure
- Sub-module nor_cell: one switch-level slice with ports a, b, y (1 bit each), containing exactly 2 pmos, 2 nmos, supply1, supply0.
- univ_nor: a generate loop instantiating WIDTH nor_cell slices, plus the out_q register process.
- Shared package univ_gate_pkg, for use by the sibling universal-gate cells:
  - MAX_WIDTH = 64;
  - OUT_Q_RESET = 1'b0.
- No typedefs are needed.

## Test plan
- WIDTH=1, clk/rst_n unconnected. a toggles every 10 ns, b every 20 ns, both start at 0; run to 200 ns. Required out:
  - 0–10 ns: 1;
  - 10–20 ns: 0 (a=1, b=0);
  - 20–30 ns: 0 (a=0, b=1);
  - 30–40 ns: 0 (1,1).
  - The pattern repeats every 40 ns, with no X on out after t=0.
- Reset: rst_n=0 for 2 edges with a=b=0 -> out_q=0 while out=1. Release rst_n -> out_q=1 after the next rising edge.
- Latency: with rst_n=1, change a from 0 to 1 just after an edge -> out=0 immediately; out_q stays 1 until the following rising edge, then becomes 0.
- Mid-operation reset: with out_q=1 and inputs held at 0,0, pulse rst_n low for one edge -> out_q=0 for exactly that cycle, then returns to 1.
- WIDTH=8: a=8'hF0, b=8'h0C -> out=8'h03, and out_q=8'h03 one cycle later. Then a=8'h00, b=8'h00 -> out=8'hFF.
- X propagation: a=1'bx, b=1 -> out=0. a=1'bx, b=0 -> out=X.
